// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU word type and memory arbiter enums
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE,
        IACC,
        DACC,
        ERR
    } arb_state_t;

    typedef enum logic {
        GNT_I,
        GNT_D
    } arb_grant_t;

endpackage

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - alternating-on-conflict arbiter for the shared memory port
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic  CLK,
    input  logic  nRST,
    input  logic  iREN,
    input  word_t iaddr,
    input  logic  dREN,
    input  logic  dWEN,
    input  word_t daddr,
    input  word_t dstore,
    output logic  ihit,
    output word_t iload,
    output logic  dhit,
    output word_t dload,
    output logic  ramREN,
    output logic  ramWEN,
    output word_t ramaddr,
    output word_t ramstore,
    input  logic  ram_ack,
    input  word_t ramload,
    output logic  err
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TO_M1 = CW'(TIMEOUT - 1);

    arb_state_t     state_q, state_d;
    arb_grant_t     last_q, last_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    word_t          addr_q, addr_d;
    word_t          wdata_q, wdata_d;
    logic           wr_q, wr_d;
    logic           ihit_q, ihit_d;
    logic           dhit_q, dhit_d;
    word_t          iload_q, iload_d;
    word_t          dload_q, dload_d;
    logic           el_i, el_d;

    // A requester in its hit cycle still presents the old address, so it sits out.
    assign el_i = iREN & ~ihit_q;
    assign el_d = (dREN | dWEN) & ~dhit_q;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q <= IDLE;
            last_q  <= GNT_I;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            ihit_q  <= 1'b0;
            dhit_q  <= 1'b0;
            iload_q <= '0;
            dload_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            ihit_q  <= ihit_d;
            dhit_q  <= dhit_d;
            iload_q <= iload_d;
            dload_q <= dload_d;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wr_d    = wr_q;
        ihit_d  = 1'b0;
        dhit_d  = 1'b0;
        iload_d = iload_q;
        dload_d = dload_q;
        case (state_q)
            IDLE: begin
                if (el_i && (!el_d || last_q == GNT_D)) begin
                    state_d = IACC;
                    last_d  = GNT_I;
                    cnt_d   = '0;
                    addr_d  = iaddr;
                end else if (el_d) begin
                    state_d = DACC;
                    last_d  = GNT_D;
                    cnt_d   = '0;
                    addr_d  = daddr;
                    wdata_d = dstore;
                    wr_d    = dWEN;
                end
            end
            IACC: begin
                if (ram_ack) begin
                    iload_d = ramload;
                    ihit_d  = 1'b1;
                    state_d = IDLE;
                end else if (cnt_q == TO_M1) begin
                    state_d = ERR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DACC: begin
                if (ram_ack) begin
                    if (!wr_q) begin
                        dload_d = ramload;
                    end
                    dhit_d  = 1'b1;
                    state_d = IDLE;
                end else if (cnt_q == TO_M1) begin
                    state_d = ERR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ERR:     state_d = ERR;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ramREN = 1'b0;
        ramWEN = 1'b0;
        err    = 1'b0;
        case (state_q)
            IACC:    ramREN = 1'b1;
            DACC: begin
                ramWEN = wr_q;
                ramREN = ~wr_q;
            end
            ERR:     err = 1'b1;
            default: ;
        endcase
    end

    assign ihit     = ihit_q;
    assign dhit     = dhit_q;
    assign iload    = iload_q;
    assign dload    = dload_q;
    assign ramaddr  = addr_q;
    assign ramstore = wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - table-driven and sequence checks for mem_arbiter
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    logic  CLK, nRST;
    logic  iREN, dREN, dWEN, ram_ack;
    word_t iaddr, daddr, dstore, ramload;
    logic  ihit, dhit, ramREN, ramWEN, err;
    word_t iload, dload, ramaddr, ramstore;

    int errors = 0;
    int checks = 0;

    mem_arbiter #(.TIMEOUT(4)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .ihit(ihit), .iload(iload), .dhit(dhit), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ram_ack(ram_ack), .ramload(ramload), .err(err)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        logic  iren, dren, dwen, ack;
        word_t ia, da, ds, rl;
        logic  e_rren, e_rwen;
        word_t e_addr, e_store;
        logic  e_ihit;
        word_t e_iload;
        logic  e_dhit;
        word_t e_dload;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic ir, input logic dr, input logic dw, input logic ak,
                                input word_t ia, input word_t da, input word_t ds, input word_t rl,
                                input logic rr, input logic rw, input word_t ad, input word_t st,
                                input logic ih, input word_t il, input logic dh, input word_t dl);
        vec_t v;
        v.iren = ir; v.dren = dr; v.dwen = dw; v.ack = ak;
        v.ia = ia; v.da = da; v.ds = ds; v.rl = rl;
        v.e_rren = rr; v.e_rwen = rw; v.e_addr = ad; v.e_store = st;
        v.e_ihit = ih; v.e_iload = il; v.e_dhit = dh; v.e_dload = dl;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        iREN = 0; dREN = 0; dWEN = 0; ram_ack = 0;
        iaddr = '0; daddr = '0; dstore = '0; ramload = '0;
        repeat (2) step();
        nRST = 1'b1;
    endtask

    initial begin
        // inputs | ramREN ramWEN ramaddr ramstore | ihit iload | dhit dload
        vecs.push_back(mk(1,0,0,0, 32'h100,0,0,0,                     0,0,32'h000,32'h0,        0,32'h0,        0,32'h0));
        vecs.push_back(mk(1,0,0,1, 32'h100,0,0,32'hDEADBEEF,          1,0,32'h100,32'h0,        0,32'h0,        0,32'h0));
        vecs.push_back(mk(0,0,0,0, 0,0,0,0,                           0,0,32'h100,32'h0,        1,32'hDEADBEEF, 0,32'h0));
        vecs.push_back(mk(0,0,0,0, 0,0,0,0,                           0,0,32'h100,32'h0,        0,32'hDEADBEEF, 0,32'h0));
        vecs.push_back(mk(0,0,1,0, 0,32'h200,32'h12345678,0,          0,0,32'h100,32'h0,        0,32'hDEADBEEF, 0,32'h0));
        vecs.push_back(mk(0,0,1,0, 0,32'h200,32'h12345678,0,          0,1,32'h200,32'h12345678, 0,32'hDEADBEEF, 0,32'h0));
        vecs.push_back(mk(0,0,1,0, 0,32'h200,32'h12345678,0,          0,1,32'h200,32'h12345678, 0,32'hDEADBEEF, 0,32'h0));
        vecs.push_back(mk(0,0,1,1, 0,32'h200,32'h12345678,32'hAAAA5555,0,1,32'h200,32'h12345678, 0,32'hDEADBEEF, 0,32'h0));
        vecs.push_back(mk(0,0,0,0, 0,0,0,0,                           0,0,32'h200,32'h12345678, 0,32'hDEADBEEF, 1,32'h0));
        vecs.push_back(mk(0,1,0,0, 0,32'h300,0,0,                     0,0,32'h200,32'h12345678, 0,32'hDEADBEEF, 0,32'h0));
        vecs.push_back(mk(0,1,0,1, 0,32'h300,0,32'hCAFEF00D,          1,0,32'h300,32'h0,        0,32'hDEADBEEF, 0,32'h0));
        vecs.push_back(mk(0,0,0,0, 0,0,0,0,                           0,0,32'h300,32'h0,        0,32'hDEADBEEF, 1,32'hCAFEF00D));
        vecs.push_back(mk(1,1,0,0, 32'h400,32'h500,0,0,               0,0,32'h300,32'h0,        0,32'hDEADBEEF, 0,32'hCAFEF00D));
        vecs.push_back(mk(1,1,0,1, 32'h400,32'h500,0,32'h11111111,    1,0,32'h400,32'h0,        0,32'hDEADBEEF, 0,32'hCAFEF00D));
        vecs.push_back(mk(1,1,0,1, 32'h400,32'h500,0,32'h0,           0,0,32'h400,32'h0,        1,32'h11111111, 0,32'hCAFEF00D));
        vecs.push_back(mk(1,1,0,1, 32'h400,32'h500,0,32'h22222222,    1,0,32'h500,32'h0,        0,32'h11111111, 0,32'hCAFEF00D));
        vecs.push_back(mk(1,1,0,1, 32'h400,32'h500,0,32'h0,           0,0,32'h500,32'h0,        0,32'h11111111, 1,32'h22222222));
        vecs.push_back(mk(1,1,0,1, 32'h400,32'h500,0,32'h33333333,    1,0,32'h400,32'h0,        0,32'h11111111, 0,32'h22222222));
        vecs.push_back(mk(0,0,0,0, 0,0,0,0,                           0,0,32'h400,32'h0,        1,32'h33333333, 0,32'h22222222));
        vecs.push_back(mk(0,0,0,0, 0,0,0,0,                           0,0,32'h400,32'h0,        0,32'h33333333, 0,32'h22222222));
        vecs.push_back(mk(1,0,0,0, 32'h600,0,0,0,                     0,0,32'h400,32'h0,        0,32'h33333333, 0,32'h22222222));
        vecs.push_back(mk(1,0,0,1, 32'h600,0,0,32'h44444444,          1,0,32'h600,32'h0,        0,32'h33333333, 0,32'h22222222));
        vecs.push_back(mk(1,0,0,0, 32'h600,0,0,0,                     0,0,32'h600,32'h0,        1,32'h44444444, 0,32'h22222222));
        vecs.push_back(mk(1,0,0,0, 32'h700,0,0,0,                     0,0,32'h600,32'h0,        0,32'h44444444, 0,32'h22222222));
        vecs.push_back(mk(1,0,0,1, 32'h700,0,0,32'h55555555,          1,0,32'h700,32'h0,        0,32'h44444444, 0,32'h22222222));
        vecs.push_back(mk(0,0,0,0, 0,0,0,0,                           0,0,32'h700,32'h0,        1,32'h55555555, 0,32'h22222222));

        do_reset();
        chk("reset ihit", 32'(ihit), 0);
        chk("reset dhit", 32'(dhit), 0);
        chk("reset ramREN", 32'(ramREN), 0);
        chk("reset ramWEN", 32'(ramWEN), 0);
        chk("reset err", 32'(err), 0);
        chk("reset iload", iload, 0);
        chk("reset dload", dload, 0);
        chk("reset ramaddr", ramaddr, 0);
        chk("reset ramstore", ramstore, 0);

        foreach (vecs[k]) begin
            iREN = vecs[k].iren; dREN = vecs[k].dren; dWEN = vecs[k].dwen; ram_ack = vecs[k].ack;
            iaddr = vecs[k].ia; daddr = vecs[k].da; dstore = vecs[k].ds; ramload = vecs[k].rl;
            chk($sformatf("vec%0d ramREN", k), 32'(ramREN), 32'(vecs[k].e_rren));
            chk($sformatf("vec%0d ramWEN", k), 32'(ramWEN), 32'(vecs[k].e_rwen));
            chk($sformatf("vec%0d ramaddr", k), ramaddr, vecs[k].e_addr);
            chk($sformatf("vec%0d ramstore", k), ramstore, vecs[k].e_store);
            chk($sformatf("vec%0d ihit", k), 32'(ihit), 32'(vecs[k].e_ihit));
            chk($sformatf("vec%0d iload", k), iload, vecs[k].e_iload);
            chk($sformatf("vec%0d dhit", k), 32'(dhit), 32'(vecs[k].e_dhit));
            chk($sformatf("vec%0d dload", k), dload, vecs[k].e_dload);
            chk($sformatf("vec%0d err", k), 32'(err), 0);
            step();
        end

        // Conflict straight out of reset: data first, then strict alternation.
        do_reset();
        iREN = 1; dREN = 1; ram_ack = 1; iaddr = 32'h10; daddr = 32'h20; ramload = 32'hA5;
        for (int c = 0; c < 9; c++) begin
            chk($sformatf("fair c%0d ramREN", c), 32'(ramREN), 32'(c % 2));
            chk($sformatf("fair c%0d dhit", c), 32'(dhit), 32'(c % 4 == 2));
            chk($sformatf("fair c%0d ihit", c), 32'(ihit), 32'(c > 0 && c % 4 == 0));
            if (c % 2 == 1)
                chk($sformatf("fair c%0d ramaddr", c), ramaddr, (c % 4 == 1) ? 32'h20 : 32'h10);
            step();
        end

        // Timeout with TIMEOUT=4: four ACC cycles, then sticky ERR.
        do_reset();
        dREN = 1; daddr = 32'h80;
        for (int c = 0; c < 10; c++) begin
            if (c == 7) ram_ack = 1;
            chk($sformatf("tmo c%0d ramREN", c), 32'(ramREN), 32'(c >= 1 && c <= 4));
            chk($sformatf("tmo c%0d err", c), 32'(err), 32'(c >= 5));
            chk($sformatf("tmo c%0d ramWEN", c), 32'(ramWEN), 0);
            chk($sformatf("tmo c%0d dhit", c), 32'(dhit), 0);
            step();
        end
        do_reset();
        chk("tmo cleared err", 32'(err), 0);

        // Reset landing in the middle of a write access.
        dWEN = 1; daddr = 32'h90; dstore = 32'h77;
        step();
        chk("rst-mid ramWEN before", 32'(ramWEN), 1);
        chk("rst-mid ramaddr before", ramaddr, 32'h90);
        nRST = 0;
        step();
        nRST = 1; dWEN = 0; ram_ack = 1;
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("rst-mid c%0d ramWEN", c), 32'(ramWEN), 0);
            chk($sformatf("rst-mid c%0d ramREN", c), 32'(ramREN), 0);
            chk($sformatf("rst-mid c%0d dhit", c), 32'(dhit), 0);
            chk($sformatf("rst-mid c%0d ramaddr", c), ramaddr, 0);
            chk($sformatf("rst-mid c%0d ramstore", c), ramstore, 0);
            chk($sformatf("rst-mid c%0d err", c), 32'(err), 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
